// File: rtl/pad_input_conditioner.sv
// Per-lane pad input conditioning. Each lane has a two-flop synchronizer, a
// programmable debounce filter, edge detection and sticky interrupt pending bits.
module pad_input_conditioner #(
  parameter int N_PADS = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PADS-1:0] pad_to_core_i,
  input  logic [N_PADS-1:0] filt_en_i,
  input  logic [CNT_W-1:0]  debounce_thr_i,
  input  logic [N_PADS-1:0] irq_rise_en_i,
  input  logic [N_PADS-1:0] irq_fall_en_i,
  input  logic [N_PADS-1:0] irq_clear_i,
  output logic [N_PADS-1:0] sync_o,
  output logic [N_PADS-1:0] filt_o,
  output logic [N_PADS-1:0] rise_pulse_o,
  output logic [N_PADS-1:0] fall_pulse_o,
  output logic [N_PADS-1:0] irq_pending_o,
  output logic              irq_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_PADS-1:0] s1;
  logic [N_PADS-1:0] s2;
  logic [N_PADS-1:0] filt;
  logic [N_PADS-1:0] filt_q;
  logic [N_PADS-1:0] pending;
  logic [CNT_W-1:0]  cnt [N_PADS];
  logic [N_PADS-1:0] rise;
  logic [N_PADS-1:0] fall;
  logic [N_PADS-1:0] set_irq;

  assign rise    = filt & ~filt_q;
  assign fall    = ~filt & filt_q;
  assign set_irq = (rise & irq_rise_en_i) | (fall & irq_fall_en_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      filt    <= '0;
      filt_q  <= '0;
      pending <= '0;
      for (int i = 0; i < N_PADS; i++) cnt[i] <= '0;
    end else begin
      s1      <= pad_to_core_i;
      s2      <= s1;
      filt_q  <= filt;
      // A new set takes priority over a clear arriving in the same cycle.
      pending <= set_irq | (pending & ~irq_clear_i);
      for (int i = 0; i < N_PADS; i++) begin
        if (!filt_en_i[i]) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else if (s2[i] == filt[i]) begin
          cnt[i]  <= '0;
        end else if (cnt[i] >= debounce_thr_i) begin
          // >= so that lowering the threshold below cnt accepts immediately.
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i]  <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign sync_o        = s2;
  assign filt_o        = filt;
  assign rise_pulse_o  = rise;
  assign fall_pulse_o  = fall;
  assign irq_pending_o = pending;
  assign irq_o         = |pending;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench for pad_input_conditioner: a lane-level reference model
// pushes the expected output vector every cycle and a monitor pops and compares.
module tb_pad_input_conditioner;

  localparam int N     = 8;
  localparam int CW    = 8;
  localparam int VEC_W = 5 * N + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  pad;
  logic [N-1:0]  filt_en;
  logic [CW-1:0] thr;
  logic [N-1:0]  rise_en;
  logic [N-1:0]  fall_en;
  logic [N-1:0]  clr;
  logic [N-1:0]  sync_o, filt_o, rise_o, fall_o, pend_o;
  logic          irq_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_mon    = 0;

  logic [VEC_W-1:0] exp_q[$];

  pad_input_conditioner #(.N_PADS(N), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pad_to_core_i (pad),
    .filt_en_i     (filt_en),
    .debounce_thr_i(thr),
    .irq_rise_en_i (rise_en),
    .irq_fall_en_i (fall_en),
    .irq_clear_i   (clr),
    .sync_o        (sync_o),
    .filt_o        (filt_o),
    .rise_pulse_o  (rise_o),
    .fall_pulse_o  (fall_o),
    .irq_pending_o (pend_o),
    .irq_o         (irq_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each lane: the pad value is seen at sync two edges after sampling; the
  // clean value adopts sync once disagreement has lasted T+1 cycles in a row
  // (immediately when filtering is off). Edges of the clean value latch
  // interrupts one cycle later.
  logic [N-1:0] pad_seen [2];
  logic [N-1:0] clean;
  logic [N-1:0] clean_prev;
  logic [N-1:0] m_pend;
  int           disagree_run [N];

  function automatic logic [VEC_W-1:0] expected_vec();
    logic [N-1:0] r, f;
    r = clean & ~clean_prev;
    f = ~clean & clean_prev;
    return {pad_seen[1], clean, r, f, m_pend, |m_pend};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pad_seen[0] = '0;
      pad_seen[1] = '0;
      clean       = '0;
      clean_prev  = '0;
      m_pend      = '0;
      for (int i = 0; i < N; i++) disagree_run[i] = 0;
    end else begin
      logic [N-1:0] edge_up, edge_dn, sync_now;
      edge_up  = clean & ~clean_prev;
      edge_dn  = ~clean & clean_prev;
      m_pend   = (edge_up & rise_en) | (edge_dn & fall_en) | (m_pend & ~clr);
      sync_now = pad_seen[1];
      clean_prev = clean;
      for (int i = 0; i < N; i++) begin
        if (!filt_en[i]) begin
          clean[i] = sync_now[i];
          disagree_run[i] = 0;
        end else if (sync_now[i] == clean[i]) begin
          disagree_run[i] = 0;
        end else begin
          disagree_run[i] = disagree_run[i] + 1;
          if (disagree_run[i] >= int'(thr) + 1) begin
            clean[i] = sync_now[i];
            disagree_run[i] = 0;
          end
        end
      end
      pad_seen[1] = pad_seen[0];
      pad_seen[0] = pad;
    end
    exp_q.push_back(expected_vec());
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [VEC_W-1:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {sync_o, filt_o, rise_o, fall_o, pend_o, irq_o};
      n_mon++;
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL outputs t=%0t actual sync=%h filt=%h rise=%h fall=%h pend=%h irq=%b required sync=%h filt=%h rise=%h fall=%h pend=%h irq=%b",
                    $time, act_v[40:33], act_v[32:25], act_v[24:17], act_v[16:9], act_v[8:1], act_v[0],
                    exp_v[40:33], exp_v[32:25], exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic random_phase(input int cycles);
    logic [N-1:0] mask;
    for (int c = 0; c < cycles; c++) begin
      if (c % 80 == 0) begin
        filt_en = N'($urandom);
        thr     = CW'($urandom_range(0, 6));
        rise_en = N'($urandom);
        fall_en = N'($urandom);
      end
      for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 5) == 0);
      pad = pad ^ mask;
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      tick(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; pad = '0; filt_en = '0; thr = '0;
    rise_en = '0; fall_en = '0; clr = '0;
    tick(3);
    rst = 1'b0;

    // Bypass, T=0: lane 0 rises and latches pending via rise enable.
    rise_en = 8'h01; pad = 8'h01;
    tick(6);

    // Glitch rejection on lane 3 with T=4, then a long enough pulse.
    filt_en = 8'hFF; thr = 8'd4;
    pad[3] = 1'b1; tick(4); pad[3] = 1'b0; tick(10);
    pad[3] = 1'b1; tick(6); pad[3] = 1'b0; tick(12);

    // Threshold lowered below the running count on lane 5.
    thr = 8'd10; pad[5] = 1'b1; tick(8);
    thr = 8'd3; tick(6);

    // Set/clear collision on lane 2 in bypass.
    clr = 8'hFF; tick(1); clr = '0;
    filt_en[2] = 1'b0; rise_en[2] = 1'b1; fall_en[2] = 1'b1;
    pad[2] = 1'b1; tick(5);
    clr = 8'hFF; tick(1); clr = '0;
    pad[2] = 1'b1; rise_en[2] = 1'b0; tick(1);
    rise_en[2] = 1'b1; pad[2] = 1'b1;
    rise_en = 8'h04; fall_en = 8'h04;
    pad[2] = 1'b0; tick(3);
    clr[2] = 1'b1; tick(1); clr = '0; tick(1);
    clr[2] = 1'b1; tick(1); clr = '0; tick(2);

    // Reset mid-count with all lanes pending.
    filt_en = 8'hFF; thr = 8'd5; rise_en = 8'hFF; fall_en = 8'hFF;
    pad = 8'h00; tick(12);
    pad = 8'hFF; tick(12);
    pad = 8'h00; tick(4);
    pad = 8'hFF; tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(16);

    // Randomized independent lanes.
    random_phase(700);
    pad = '0; clr = 8'hFF; tick(20);

    check_val("monitor_ran", (n_mon > 700) ? 1 : 0, 1);
    check_val("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
